// File: rtl/keyboard_ps2_decoder.sv
// PS/2 scan-code set 2 receiver: decodes make/break sequences into held-key levels.
// Define KBD_ALT_KEYS_EN to make A (1C) and D (23) alias the left/right arrows.
module keyboard_ps2_decoder #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       rightArrow,
  output logic       leftArrow,
  output logic       spaceBar,
  output logic       spacePress,
  output logic       code_valid,
  output logic [7:0] code_byte,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d, fall_q, fall_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic          right_q, right_d, left_q, left_d, space_q, space_d;
  logic          a_q, a_d, d_q, d_d;
  logic          press_q, press_d, valid_q, valid_d, err_q, err_d;
  logic [7:0]    byte_q, byte_d;
  logic          good;

  always_comb begin
    filt_d    = filt_q;
    fcnt_d    = '0;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_cnt_d  = TW'(TIMEOUT_CYCLES - 1);
    ext_d     = ext_q;
    brk_d     = brk_q;
    right_d   = right_q;
    left_d    = left_q;
    space_d   = space_q;
    a_d       = a_q;
    d_d       = d_q;
    press_d   = 1'b0;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    byte_d    = byte_q;
    good      = 1'b0;

    // The filtered clock only flips after FILTER_LEN disagreeing samples in a row.
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
      else                               fcnt_d = fcnt_q + 1'b1;
    end
    fall_d = filt_q & ~filt_d;

    case (state_q)
      IDLE: if (fall_q && !dat_s2_q) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: if (fall_q) begin
        shift_d   = {dat_s2_q, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall_q) begin
        par_d   = dat_s2_q;
        state_d = STOP;
      end
      STOP: if (fall_q) begin
        state_d = IDLE;
        if (dat_s2_q && (^shift_q ^ par_q)) good  = 1'b1;
        else                                err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && !fall_q) begin
      if (to_cnt_q == '0) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q - 1'b1;
      end
    end

    if (err_d) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end

    if (good) begin
      valid_d = 1'b1;
      byte_d  = shift_q;
      case (shift_q)
        8'hE0: ext_d = 1'b1;
        8'hF0: brk_d = 1'b1;
        default: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          if (ext_q && shift_q == 8'h74) right_d = !brk_q;
          if (ext_q && shift_q == 8'h6B) left_d  = !brk_q;
          if (!ext_q && shift_q == 8'h29) begin
            space_d = !brk_q;
            press_d = !brk_q && !space_q;
          end
`ifdef KBD_ALT_KEYS_EN
          if (!ext_q && shift_q == 8'h1C) a_d = !brk_q;
          if (!ext_q && shift_q == 8'h23) d_d = !brk_q;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      filt_q    <= 1'b1;
      fcnt_q    <= '0;
      fall_q    <= 1'b0;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= TW'(TIMEOUT_CYCLES - 1);
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      right_q   <= 1'b0;
      left_q    <= 1'b0;
      space_q   <= 1'b0;
      a_q       <= 1'b0;
      d_q       <= 1'b0;
      press_q   <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      byte_q    <= 8'h00;
    end else begin
      clk_s1_q  <= ps2_clk;
      clk_s2_q  <= clk_s1_q;
      dat_s1_q  <= ps2_data;
      dat_s2_q  <= dat_s1_q;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      fall_q    <= fall_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      right_q   <= right_d;
      left_q    <= left_d;
      space_q   <= space_d;
      a_q       <= a_d;
      d_q       <= d_d;
      press_q   <= press_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      byte_q    <= byte_d;
    end
  end

`ifdef KBD_ALT_KEYS_EN
  assign rightArrow = right_q | d_q;
  assign leftArrow  = left_q | a_q;
`else
  assign rightArrow = right_q;
  assign leftArrow  = left_q;
`endif
  assign spaceBar   = space_q;
  assign spacePress = press_q;
  assign code_valid = valid_q;
  assign code_byte  = byte_q;
  assign frame_err  = err_q;

endmodule
